// File: rtl/rst_seq_ctrl_pkg.sv
// Shared definitions for the power-up / reset sequencer: state codes,
// default 50 MHz cycle constants and the state-to-output decode.
package rst_seq_ctrl_pkg;

  // State codes; the numeric values are visible on seq_state.
  typedef enum logic [3:0] {
    ST_PLL_RST    = 4'd0,
    ST_WAIT_LOCK  = 4'd1,
    ST_CAM_PWR    = 4'd2,
    ST_CAM_RST    = 4'd3,
    ST_SDRAM      = 4'd4,
    ST_CAM_SETTLE = 4'd5,
    ST_CFG        = 4'd6,
    ST_RUN        = 4'd7
  } seq_state_e;

  // Default cycle counts for a 50 MHz oscillator.
  localparam int DEF_PLL_RST_CYC    = 16;
  localparam int DEF_CAM_PWDN_CYC   = 50_000;     // 1 ms
  localparam int DEF_CAM_RST_CYC    = 50_000;     // 1 ms
  localparam int DEF_CAM_SETTLE_CYC = 1_000_000;  // 20 ms
  localparam int DEF_TIMEOUT_CYC    = 2_000_000;  // 40 ms
  localparam int DEF_CNT_W          = 21;

  localparam logic [3:0] LOCK_LOSS_MAX = 4'hF;

  // Registered pin values, all decoded from a single state.
  typedef struct packed {
    logic pll_areset;
    logic cam_pwdn;
    logic cam_rst_n;
    logic sdram_rst_n;
    logic cfg_rst_n;
    logic disp_rst_n;
    logic seq_done;
  } seq_out_t;

  // Releases are cumulative, so each output is a threshold on the state code.
  function automatic seq_out_t decode_outputs(input seq_state_e st);
    seq_out_t o;
    o.pll_areset  = (st == ST_PLL_RST);
    o.cam_pwdn    = (st <= ST_CAM_PWR);
    o.cam_rst_n   = (st >= ST_SDRAM);
    o.sdram_rst_n = (st >= ST_SDRAM);
    o.cfg_rst_n   = (st >= ST_CFG);
    o.disp_rst_n  = (st == ST_RUN);
    o.seq_done    = (st == ST_RUN);
    return o;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer, asynchronously cleared to 0.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make both flops sample their old
      // values on the same edge; blocking here would collapse the chain.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Power-up and reset sequencer for the camera-to-TFT system.
// Runs from the ungated board oscillator. Optional build macro
// RST_SEQ_TIMEOUT_EN bounds the WAIT_LOCK, SDRAM and CFG waits to
// TIMEOUT_CYC cycles and sets the sticky seq_err on expiry.
module rst_seq_ctrl
  import rst_seq_ctrl_pkg::*;
#(
  parameter int PLL_RST_CYC    = DEF_PLL_RST_CYC,
  parameter int CAM_PWDN_CYC   = DEF_CAM_PWDN_CYC,
  parameter int CAM_RST_CYC    = DEF_CAM_RST_CYC,
  parameter int CAM_SETTLE_CYC = DEF_CAM_SETTLE_CYC,
  parameter int TIMEOUT_CYC    = DEF_TIMEOUT_CYC,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       pll_locked,
  input  logic       sdram_init_done,
  input  logic       cam_cfg_done,
  output logic       pll_areset,
  output logic       cam_pwdn,
  output logic       cam_rst_n,
  output logic       sdram_rst_n,
  output logic       cfg_rst_n,
  output logic       disp_rst_n,
  output logic       seq_done,
  output logic [3:0] seq_state,
  output logic [3:0] lock_loss_cnt,
  output logic       seq_err
);

  localparam logic [CNT_W-1:0] LIM_PLL_RST    = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] LIM_CAM_PWDN   = CNT_W'(CAM_PWDN_CYC - 1);
  localparam logic [CNT_W-1:0] LIM_CAM_RST    = CNT_W'(CAM_RST_CYC - 1);
  localparam logic [CNT_W-1:0] LIM_CAM_SETTLE = CNT_W'(CAM_SETTLE_CYC - 1);
  // Wait-state limit; only acted on when the timeout feature is built,
  // otherwise the comparison result is unused and optimises away.
  localparam logic [CNT_W-1:0] LIM_TIMEOUT    = CNT_W'(TIMEOUT_CYC - 1);

  logic lock_s, sdram_done_s, cfg_done_s;

  sync_2ff u_sync_lock  (.i_clk(i_clk), .i_rst_n(i_rst_n), .d(pll_locked),      .q(lock_s));
  sync_2ff u_sync_sdram (.i_clk(i_clk), .i_rst_n(i_rst_n), .d(sdram_init_done), .q(sdram_done_s));
  sync_2ff u_sync_cfg   (.i_clk(i_clk), .i_rst_n(i_rst_n), .d(cam_cfg_done),    .q(cfg_done_s));

  seq_state_e       state, state_nxt;
  logic [CNT_W-1:0] timer, timer_lim;
  logic             timer_hit;
  logic             lock_loss;
  logic             timeout;
  seq_out_t         outs;

  // Select the exit count for the current state; one comparator is shared.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would infer a latch.
    timer_lim = LIM_TIMEOUT;
    case (state)
      ST_PLL_RST:    timer_lim = LIM_PLL_RST;
      ST_CAM_PWR:    timer_lim = LIM_CAM_PWDN;
      ST_CAM_RST:    timer_lim = LIM_CAM_RST;
      ST_CAM_SETTLE: timer_lim = LIM_CAM_SETTLE;
      default:       timer_lim = LIM_TIMEOUT;
    endcase
  end

  assign timer_hit = (timer == timer_lim);

  // Next-state logic; lock loss overrides any normal or timeout exit.
  always_comb begin
    state_nxt = state;
    lock_loss = 1'b0;
    timeout   = 1'b0;
    case (state)
      ST_PLL_RST:    if (timer_hit) state_nxt = ST_WAIT_LOCK;
      ST_WAIT_LOCK:  if (lock_s) state_nxt = ST_CAM_PWR;
`ifdef RST_SEQ_TIMEOUT_EN
                     else if (timer_hit) begin state_nxt = ST_PLL_RST; timeout = 1'b1; end
`endif
      ST_CAM_PWR:    if (timer_hit) state_nxt = ST_CAM_RST;
      ST_CAM_RST:    if (timer_hit) state_nxt = ST_SDRAM;
      ST_SDRAM:      if (sdram_done_s) state_nxt = ST_CAM_SETTLE;
`ifdef RST_SEQ_TIMEOUT_EN
                     else if (timer_hit) begin state_nxt = ST_PLL_RST; timeout = 1'b1; end
`endif
      ST_CAM_SETTLE: if (timer_hit) state_nxt = ST_CFG;
      ST_CFG:        if (cfg_done_s) state_nxt = ST_RUN;
`ifdef RST_SEQ_TIMEOUT_EN
                     else if (timer_hit) begin state_nxt = ST_PLL_RST; timeout = 1'b1; end
`endif
      ST_RUN:        state_nxt = ST_RUN;
      default:       state_nxt = ST_PLL_RST;
    endcase
    // Lock is expected to be low before CAM_PWR; after that it is an event.
    if (state >= ST_CAM_PWR && !lock_s) begin
      state_nxt = ST_PLL_RST;
      lock_loss = 1'b1;
      timeout   = 1'b0;
    end
  end

  // State register and shared timer, cleared on every transition.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_PLL_RST;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= (state_nxt != state) ? '0 : timer + CNT_W'(1);
    end
  end

  // Output register decoded from the next state: glitch-free, same edge as state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) outs <= decode_outputs(ST_PLL_RST);
    else          outs <= decode_outputs(state_nxt);
  end

  // Saturating count of lock-loss re-sequences.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                 lock_loss_cnt <= '0;
    else if (lock_loss && lock_loss_cnt != LOCK_LOSS_MAX) lock_loss_cnt <= lock_loss_cnt + 4'd1;
  end

`ifdef RST_SEQ_TIMEOUT_EN
  logic seq_err_q;
  // Sticky timeout flag, cleared only by i_rst_n.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     seq_err_q <= 1'b0;
    else if (timeout) seq_err_q <= 1'b1;
  end
  assign seq_err = seq_err_q;
`else
  assign seq_err = 1'b0;
  logic unused_timeout;
  assign unused_timeout = timeout;
`endif

  assign seq_state   = state;
  assign pll_areset  = outs.pll_areset;
  assign cam_pwdn    = outs.cam_pwdn;
  assign cam_rst_n   = outs.cam_rst_n;
  assign sdram_rst_n = outs.sdram_rst_n;
  assign cfg_rst_n   = outs.cfg_rst_n;
  assign disp_rst_n  = outs.disp_rst_n;
  assign seq_done    = outs.seq_done;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed testbench for rst_seq_ctrl with shortened cycle counts.
// Exercises the optional timeout path when RST_SEQ_TIMEOUT_EN is defined.
module tb_rst_seq_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       pll_locked, sdram_init_done, cam_cfg_done;
  logic       pll_areset, cam_pwdn, cam_rst_n, sdram_rst_n, cfg_rst_n, disp_rst_n, seq_done;
  logic [3:0] seq_state, lock_loss_cnt;
  logic       seq_err;

  int n_checks = 0;
  int n_errors = 0;

  localparam int SIG_PLL_ARESET = 0;
  localparam int SIG_CAM_PWDN   = 1;
  localparam int SIG_CAM_RST_N  = 2;
  localparam int SIG_CFG_RST_N  = 3;
  localparam int SIG_SEQ_DONE   = 4;

  // {pll_areset, cam_pwdn, cam_rst_n, sdram_rst_n, cfg_rst_n, disp_rst_n, seq_done}
  localparam logic [6:0] OUTS_RESET = 7'b1100000;
  localparam logic [6:0] OUTS_RUN   = 7'b0011111;

  rst_seq_ctrl #(
    .PLL_RST_CYC(4), .CAM_PWDN_CYC(10), .CAM_RST_CYC(10),
    .CAM_SETTLE_CYC(20), .TIMEOUT_CYC(100), .CNT_W(21)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .pll_locked(pll_locked),
    .sdram_init_done(sdram_init_done), .cam_cfg_done(cam_cfg_done),
    .pll_areset(pll_areset), .cam_pwdn(cam_pwdn), .cam_rst_n(cam_rst_n),
    .sdram_rst_n(sdram_rst_n), .cfg_rst_n(cfg_rst_n), .disp_rst_n(disp_rst_n),
    .seq_done(seq_done), .seq_state(seq_state), .lock_loss_cnt(lock_loss_cnt),
    .seq_err(seq_err)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] outs_vec();
    return {pll_areset, cam_pwdn, cam_rst_n, sdram_rst_n, cfg_rst_n, disp_rst_n, seq_done};
  endfunction

  function automatic logic probe(input int sel);
    case (sel)
      SIG_PLL_ARESET: return pll_areset;
      SIG_CAM_PWDN:   return cam_pwdn;
      SIG_CAM_RST_N:  return cam_rst_n;
      SIG_CFG_RST_N:  return cfg_rst_n;
      default:        return seq_done;
    endcase
  endfunction

  // Number of negedges until the selected output reaches val (bounded).
  task automatic count_until(input int sel, input logic val, input int budget, output int n);
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (probe(sel) !== val && n < budget);
  endtask

  // Number of negedges until seq_state equals code (bounded).
  task automatic wait_state(input logic [3:0] code, input int budget, output int n);
    n = 0;
    while (seq_state !== code && n < budget) begin
      @(negedge i_clk);
      n++;
    end
  endtask

  task automatic reset_pulse();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    int n;
    i_rst_n = 1'b0;
    pll_locked = 1'b0;
    sdram_init_done = 1'b0;
    cam_cfg_done = 1'b0;
    repeat (3) @(negedge i_clk);

    // Reset values.
    check("reset_outs",  outs_vec(),    OUTS_RESET);
    check("reset_state", seq_state,     4'd0);
    check("reset_cnt",   lock_loss_cnt, 4'd0);
    check("reset_err",   seq_err,       1'b0);

    // Nominal sequence.
    i_rst_n = 1'b1;
    count_until(SIG_PLL_ARESET, 1'b0, 50, n);
    check("pll_areset_cycles", n, 4);
    check("wait_lock_state", seq_state, 4'd1);
    repeat (16) @(negedge i_clk);
    check("wait_lock_hold", seq_state, 4'd1);
    pll_locked = 1'b1;
    wait_state(4'd2, 20, n);
    check("lock_latency", n, 3);
    check("cam_pwr_outs", outs_vec(), 7'b0100000);
    count_until(SIG_CAM_PWDN, 1'b0, 50, n);
    check("cam_pwdn_cycles", n, 10);
    check("cam_rst_state", seq_state, 4'd3);
    count_until(SIG_CAM_RST_N, 1'b1, 50, n);
    check("cam_rst_cycles", n, 10);
    check("sdram_outs", outs_vec(), 7'b0011000);
    repeat (30) @(negedge i_clk);
    check("sdram_wait", seq_state, 4'd4);
    sdram_init_done = 1'b1;
    wait_state(4'd5, 20, n);
    check("sdram_done_latency", n, 3);
    count_until(SIG_CFG_RST_N, 1'b1, 50, n);
    check("cam_settle_cycles", n, 20);
    check("cfg_state", seq_state, 4'd6);
    check("cfg_disp_held", disp_rst_n, 1'b0);
    repeat (15) @(negedge i_clk);
    cam_cfg_done = 1'b1;
    count_until(SIG_SEQ_DONE, 1'b1, 20, n);
    check("cfg_done_latency", n, 3);
    check("run_outs", outs_vec(), OUTS_RUN);
    check("run_state", seq_state, 4'd7);

    // A done flag dropping in RUN is ignored.
    sdram_init_done = 1'b0;
    repeat (5) @(negedge i_clk);
    check("done_drop_ignored", seq_state, 4'd7);
    sdram_init_done = 1'b1;

    // Lock loss in RUN.
    @(negedge i_clk);
    pll_locked = 1'b0;
    wait_state(4'd0, 10, n);
    check("lock_loss_latency", n, 3);
    check("lock_loss_outs", outs_vec(), OUTS_RESET);
    check("lock_loss_cnt1", lock_loss_cnt, 4'd1);
    repeat (2) @(negedge i_clk);
    pll_locked = 1'b1;
    wait_state(4'd7, 300, n);
    check("resequence_run", seq_state, 4'd7);
    check("resequence_outs", outs_vec(), OUTS_RUN);
    check("wait_lock_not_counted", lock_loss_cnt, 4'd1);

    // Saturation: 16 more lock-loss events (17 total).
    for (int i = 2; i <= 17; i++) begin
      pll_locked = 1'b0;
      wait_state(4'd0, 10, n);
      check("sat_to_pll_rst", seq_state, 4'd0);
      pll_locked = 1'b1;
      wait_state(4'd2, 50, n);
      check("sat_to_cam_pwr", seq_state, 4'd2);
      if (i == 14) check("cnt_14", lock_loss_cnt, 4'd14);
    end
    check("cnt_saturated", lock_loss_cnt, 4'd15);

    // Asynchronous reset in CAM_SETTLE.
    wait_state(4'd5, 100, n);
    check("reach_cam_settle", seq_state, 4'd5);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("async_outs",  outs_vec(),    OUTS_RESET);
    check("async_state", seq_state,     4'd0);
    check("async_cnt",   lock_loss_cnt, 4'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    count_until(SIG_PLL_ARESET, 1'b0, 50, n);
    check("restart_pll_areset", n, 4);
    wait_state(4'd7, 300, n);
    check("restart_run", seq_state, 4'd7);

`ifdef RST_SEQ_TIMEOUT_EN
    // SDRAM never finishes: timeout after 100 cycles, full retry.
    sdram_init_done = 1'b0;
    reset_pulse();
    wait_state(4'd4, 200, n);
    check("to_reach_sdram", seq_state, 4'd4);
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (seq_state !== 4'd0 && n < 300);
    check("timeout_cycles", n, 100);
    check("timeout_err", seq_err, 1'b1);
    check("timeout_cnt", lock_loss_cnt, 4'd0);
    sdram_init_done = 1'b1;
    wait_state(4'd7, 300, n);
    check("retry_run", seq_state, 4'd7);
    check("err_sticky", seq_err, 1'b1);
`else
    // Without the timeout feature the SDRAM wait is unbounded.
    sdram_init_done = 1'b0;
    reset_pulse();
    wait_state(4'd4, 200, n);
    check("nto_reach_sdram", seq_state, 4'd4);
    repeat (10000) @(negedge i_clk);
    check("nto_state", seq_state, 4'd4);
    check("nto_err", seq_err, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
